// File: rtl/seq_divider_if.sv
// Request/result bundle for the sequential divider.
// master drives operands and start; slave returns the handshake and results.
interface seq_divider_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             signed_mode;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    modport master (
        output start, signed_mode, dividend, divisor,
        input  busy, done, div_by_zero, quotient, remainder
    );

    modport slave (
        input  start, signed_mode, dividend, divisor,
        output busy, done, div_by_zero, quotient, remainder
    );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider (DIV/REM unit): one quotient bit per cycle on
// operand magnitudes, sign fix-up in a final cycle, zero-divisor short path.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_rem_hi;
    logic [WIDTH-1:0] r_rem_lo;
    logic [WIDTH-1:0] r_dvsr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_q_neg;
    logic             r_r_neg;
    logic             r_zero;
    logic             r_busy;
    logic             r_done;
    logic             r_dbz;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;

    logic             w_a_neg;
    logic             w_b_neg;
    logic             w_b_zero;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH-1:0] w_shift_hi;
    logic [WIDTH:0]   w_diff;

    assign w_a_neg  = bus.signed_mode & bus.dividend[WIDTH-1];
    assign w_b_neg  = bus.signed_mode & bus.divisor[WIDTH-1];
    assign w_b_zero = (bus.divisor == '0);
    // Most-negative value maps to 2^(WIDTH-1), which still fits unsigned.
    assign w_a_mag  = w_a_neg ? -bus.dividend : bus.dividend;
    assign w_b_mag  = w_b_neg ? -bus.divisor  : bus.divisor;

    // After k shifts rem_hi holds at most k dividend bits, so no carry is lost.
    assign w_shift_hi = {r_rem_hi[WIDTH-2:0], r_rem_lo[WIDTH-1]};
    assign w_diff     = {1'b0, w_shift_hi} - {1'b0, r_dvsr};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_rem_hi <= '0;
            r_rem_lo <= '0;
            r_dvsr   <= '0;
            r_cnt    <= '0;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
            r_zero   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
            r_quot   <= '0;
            r_rem    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        // Zero divisor keeps the raw dividend for the remainder.
                        r_rem_lo <= w_b_zero ? bus.dividend : w_a_mag;
                        r_rem_hi <= '0;
                        r_dvsr   <= w_b_mag;
                        r_q_neg  <= w_a_neg ^ w_b_neg;
                        r_r_neg  <= w_a_neg;
                        r_zero   <= w_b_zero;
                        r_dbz    <= 1'b0;
                        r_cnt    <= CNT_W'(WIDTH - 1);
                        r_busy   <= 1'b1;
                        r_state  <= w_b_zero ? S_FIX : S_CALC;
                    end
                end
                S_CALC: begin
                    r_rem_lo <= {r_rem_lo[WIDTH-2:0], ~w_diff[WIDTH]};
                    r_rem_hi <= w_diff[WIDTH] ? w_shift_hi : w_diff[WIDTH-1:0];
                    r_cnt    <= r_cnt - CNT_W'(1);
                    if (r_cnt == '0)
                        r_state <= S_FIX;
                end
                S_FIX: begin
                    if (r_zero) begin
                        r_quot <= '1;
                        r_rem  <= r_rem_lo;
                    end else begin
                        r_quot <= r_q_neg ? -r_rem_lo : r_rem_lo;
                        r_rem  <= r_r_neg ? -r_rem_hi : r_rem_hi;
                    end
                    r_dbz   <= r_zero;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;
    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_rem;
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Parametrised multi-cycle restoring divider. It is the self-contained successor of the fixed 32-bit remainder-register datapath, integrating the shift register, the (WIDTH+1)-bit subtract ALU and the iteration control. It adds signed/unsigned mode, divide-by-zero handling, a start/busy/done handshake and latched result registers. It sits beside the ALU as the DIV/REM execution unit.

Parameters:
WIDTH, 32, operand/result width in bits (>=4)
CNT_W, $clog2(WIDTH), iteration counter width (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  request; sampled only in IDLE
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; latched with start
dividend  input  WIDTH  dividend; latched with start
divisor  input  WIDTH  divisor; latched with start
busy  output  1  high from the edge accepting start until the FIX edge
done  output  1  one-cycle pulse: results valid
div_by_zero  output  1  divisor was zero for the latched operation; valid with done, held
quotient  output  WIDTH  quotient, held until next accepted start
remainder  output  WIDTH  remainder, held until next accepted start

Behaviour:
- Reset (rst low, async): state=IDLE; busy, done, div_by_zero=0; quotient, remainder=0; internal {rem_hi, rem_lo} (2*WIDTH), counter=0.
- Reset mid-operation aborts immediately. No partial result is kept. First start after release is accepted normally.
- States: IDLE, CALC, FIX.
- IDLE: start=1 at edge E0:
  - Latch the mode.
  - Load rem_lo with |dividend|; in unsigned mode the raw value.
  - Latch |divisor|.
  - Record the result signs: q_neg = sign(dividend) XOR sign(divisor); r_neg = sign(dividend). Both are 0 when unsigned.
  - Set rem_hi=0, counter=WIDTH-1, busy=1.
  - Go to CALC, or straight to FIX if divisor==0.
- CALC, one bit per edge:
  - Shift {rem_hi,rem_lo} left by 1.
  - diff = {1'b0, shifted rem_hi} - {1'b0, divisor} in WIDTH+1 bits.
  - If diff[WIDTH]==0: rem_hi = diff[WIDTH-1:0], rem_lo[0]=1. Otherwise restore, rem_lo[0]=0.
  - The counter decrements. The edge where counter==0 moves to FIX. CALC spans exactly WIDTH edges (E0+1..E0+WIDTH).
- FIX (one edge):
  - quotient = q_neg ? -rem_lo : rem_lo.
  - remainder = r_neg ? -rem_hi : rem_hi.
  - done=1, busy=0, state=IDLE.
  - done drops on the next edge.
- Latency: done high in the cycle after edge E0+WIDTH+1. Zero divisor: done high after edge E0+1.
- Divide by zero: quotient = all ones; remainder = original dividend (unsigned bit pattern, no sign fix); div_by_zero=1.
- div_by_zero clears at the next accepted start.
- Signed overflow (most-negative / -1): quotient = most-negative, remainder=0, div_by_zero=0. This falls out of the magnitude arithmetic; no special case is needed.
- start while busy or in FIX is ignored. Operand inputs may change freely after E0.
- start held high continuously: a new operation is accepted on the edge after done rises (the FIX→IDLE edge puts the block in IDLE). Back-to-back throughput is WIDTH+2 cycles.
- quotient/remainder change only at the FIX edge or on reset, never during CALC.
- Magnitude of the most-negative operand is 2^(WIDTH-1) in WIDTH bits (unsigned interpretation); no extra bit is required.

Test Plan:
- WIDTH=32, unsigned 100/7, start at E0 -> busy for 33 cycles; done pulse after E0+33; quotient=0x0000000E, remainder=0x00000002, div_by_zero=0.
- WIDTH=32, signed -7/2 (0xFFFFFFF9/0x00000002) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Then 7/-2 -> quotient=0xFFFFFFFD, remainder=0x00000001.
- WIDTH=32, 0x00001234/0 (either mode) -> done after E0+1; quotient=0xFFFFFFFF, remainder=0x00001234, div_by_zero=1. The next valid op clears the flag.
- WIDTH=32, signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_by_zero=0. Unsigned 0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0.
- Handshake:
  - Pulse start again at E0+5 with different operands -> ignored; the result matches the first operands.
  - Assert rst low at E0+10 -> busy=0, quotient=remainder=0 immediately.
  - A new start after release -> a correct result.
- WIDTH=8 instance, unsigned 0xFF/0x10 -> done after E0+9, quotient=0x0F, remainder=0x0F.
  - start held high through done -> a second op accepted on the edge after done.
  - Second done 10 cycles after the first.
